// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory arbiter.
//   - IMEM_ADDR_W / IMEM_DATA_W : default BRAM word-address and data widths
//   - owner_e                   : which requester owns the in-flight read
//   - inflight_t                : in-flight register {vld, owner, err}
//   - IMEM_ALIGN_MASK / IMEM_RANGE_SHIFT and imem_addr_bad(): address check
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   err;
    } inflight_t;

    // Byte address must be word aligned and must fit in 2^(ADDR_W+2) bytes.
    localparam logic [31:0] IMEM_ALIGN_MASK  = 32'h0000_0003;
    localparam int          IMEM_RANGE_SHIFT = IMEM_ADDR_W + 2;

    function automatic logic imem_addr_bad(input logic [31:0] addr, input int range_shift);
        return ((addr & IMEM_ALIGN_MASK) != 32'd0) || ((addr >> range_shift) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: request/response and BRAM signals of the instruction
// memory arbiter.
//   fetch : if_req_valid/if_req_addr/if_req_ready, if_flush,
//           if_resp_valid/if_resp_data/if_resp_err
//   debug : dbg_req_valid/dbg_req_addr/dbg_req_ready,
//           dbg_resp_valid/dbg_resp_data/dbg_resp_err
//   BRAM  : mem_en/mem_addr (to BRAM), mem_dout (from BRAM, one cycle later)
// Modports: slave = arbiter view, master = requester/BRAM view.
//
// Handshake: a request transfers in a cycle where valid and ready are both
// high; ready is combinational and never high without its valid. Responses
// have no backpressure: resp_valid is a one-cycle strobe the consumer must
// take in the cycle it is shown.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);
    logic              if_req_valid;
    logic [31:0]       if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              if_resp_err;

    logic              dbg_req_valid;
    logic [31:0]       dbg_req_addr;
    logic              dbg_req_ready;
    logic              dbg_resp_valid;
    logic [DATA_W-1:0] dbg_resp_data;
    logic              dbg_resp_err;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  dbg_req_valid, dbg_req_addr,
        input  mem_dout,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output dbg_req_ready, dbg_resp_valid, dbg_resp_data, dbg_resp_err,
        output mem_en, mem_addr
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output dbg_req_valid, dbg_req_addr,
        output mem_dout,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  dbg_req_ready, dbg_resp_valid, dbg_resp_data, dbg_resp_err,
        input  mem_en, mem_addr
    );

endinterface

// File: rtl/imem_rr_pick.sv
// imem_rr_pick: two-way combinational grant picker.
//   clk      : clock (only present with IMEM_ARB_RR_EN, for the pointer)
//   reset    : synchronous active-high; suppresses any grant this cycle
//   req_if   : fetch eligible (valid and not flushed)
//   req_dbg  : debug eligible
//   gnt_if   : fetch granted (one-hot with gnt_dbg)
//   gnt_dbg  : debug granted
// Configuration macro IMEM_ARB_RR_EN: defined -> round robin on conflict,
// pointer moves away from the last winner on every grant; undefined ->
// fixed priority, fetch beats debug, no pointer state.
module imem_rr_pick (
`ifdef IMEM_ARB_RR_EN
    input  logic clk,
`endif
    input  logic reset,
    input  logic req_if,
    input  logic req_dbg,
    output logic gnt_if,
    output logic gnt_dbg
);

`ifdef IMEM_ARB_RR_EN
    // 1 = debug won the last grant, so fetch is preferred on the next conflict.
    logic last_dbg;

    always_comb begin
        gnt_if  = 1'b0;
        gnt_dbg = 1'b0;
        if (!reset) begin
            if (req_if && req_dbg) begin
                gnt_if  = last_dbg;
                gnt_dbg = !last_dbg;
            end else begin
                gnt_if  = req_if;
                gnt_dbg = req_dbg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dbg <= 1'b1;
        end else if (gnt_if || gnt_dbg) begin
            last_dbg <= gnt_dbg;
        end
    end
`else
    always_comb begin
        gnt_if  = !reset && req_if;
        gnt_dbg = !reset && req_dbg && !req_if;
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single read port of the instruction BRAM between
// the fetch stage and a debug reader.
//   clk, reset : clock, synchronous active-high reset
//   bus        : imem_arbiter_if.slave (fetch/debug request+response, BRAM)
// One request is granted per cycle; the BRAM is read in the grant cycle and
// the registered BRAM output is routed back to the owner one cycle later.
// Misaligned or out-of-range addresses still take the grant slot but skip
// the BRAM read and return err=1 with zero data.
// Configuration macro IMEM_ARB_RR_EN selects round robin vs fixed priority
// (inside imem_rr_pick).
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus
);

    localparam int RANGE_SHIFT = ADDR_W + 2;

    logic        gnt_if;
    logic        gnt_dbg;
    logic        accept;
    logic [31:0] sel_addr;
    logic        sel_err;
    inflight_t   infl;
    logic        if_live;
    logic        dbg_live;

    // A flushing fetch stage must not start a new read.
    imem_rr_pick u_pick (
`ifdef IMEM_ARB_RR_EN
        .clk     (clk),
`endif
        .reset   (reset),
        .req_if  (bus.if_req_valid && !bus.if_flush),
        .req_dbg (bus.dbg_req_valid),
        .gnt_if  (gnt_if),
        .gnt_dbg (gnt_dbg)
    );

    assign accept   = gnt_if || gnt_dbg;
    assign sel_addr = gnt_dbg ? bus.dbg_req_addr : bus.if_req_addr;
    assign sel_err  = imem_addr_bad(sel_addr, RANGE_SHIFT);

    assign bus.if_req_ready  = gnt_if;
    assign bus.dbg_req_ready = gnt_dbg;
    assign bus.mem_en        = accept && !sel_err;
    assign bus.mem_addr      = accept ? sel_addr[ADDR_W+1:2] : {ADDR_W{1'b0}};

    // Reloaded every cycle: one response slot per granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            infl.vld   <= 1'b0;
            infl.owner <= OWN_IF;
            infl.err   <= 1'b0;
        end else begin
            infl.vld   <= accept;
            infl.owner <= gnt_dbg ? OWN_DBG : OWN_IF;
            infl.err   <= sel_err;
        end
    end

    // Reset drops the response already in flight in the same cycle; a fetch
    // redirect kills only a fetch-owned response.
    assign if_live  = infl.vld && (infl.owner == OWN_IF) && !bus.if_flush && !reset;
    assign dbg_live = infl.vld && (infl.owner == OWN_DBG) && !reset;

    assign bus.if_resp_valid  = if_live;
    assign bus.if_resp_err    = if_live && infl.err;
    assign bus.if_resp_data   = (if_live && !infl.err) ? bus.mem_dout : {DATA_W{1'b0}};

    assign bus.dbg_resp_valid = dbg_live;
    assign bus.dbg_resp_err   = dbg_live && infl.err;
    assign bus.dbg_resp_data  = (dbg_live && !infl.err) ? bus.mem_dout : {DATA_W{1'b0}};

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and randomized bench for imem_arbiter.
// BRAM content is word i = i. The reference model works on byte addresses
// with plain arithmetic and keeps expected responses in a queue.
module tb_imem_arbiter;

    typedef struct {
        logic        is_dbg;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    imem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // BRAM model: registered read, word i holds i.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_dout <= {22'd0, bus.mem_addr};
    end

    resp_t exp_q[$];
    logic  last_dbg;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
            1:       a = $urandom() | 32'h0000_1000;
            default: a = $urandom_range(0, 1023) << 2;
        endcase
        return a;
    endfunction

    // One clock cycle: drive inputs, check against the model at the negedge,
    // advance the model, return just after the next posedge.
    task automatic cycle(input logic rst, input logic ifv, input logic [31:0] ifa,
                         input logic fl, input logic dv, input logic [31:0] da);
        logic        el_if, el_dbg, e_if, e_dbg, prefer_if, bad, has;
        logic        e_ifv, e_dv;
        logic [31:0] a;
        resp_t       r;
        reset             = rst;
        bus.if_req_valid  = ifv;
        bus.if_req_addr   = ifa;
        bus.if_flush      = fl;
        bus.dbg_req_valid = dv;
        bus.dbg_req_addr  = da;
        @(negedge clk);
        el_if  = ifv && !fl && !rst;
        el_dbg = dv && !rst;
`ifdef IMEM_ARB_RR_EN
        prefer_if = last_dbg;
`else
        prefer_if = 1'b1;
`endif
        if (el_if && el_dbg) begin
            e_if  = prefer_if;
            e_dbg = !prefer_if;
        end else begin
            e_if  = el_if;
            e_dbg = el_dbg;
        end
        a   = e_dbg ? da : ifa;
        bad = ref_bad(a);
        chk("if_req_ready", 32'(bus.if_req_ready), 32'(e_if));
        chk("dbg_req_ready", 32'(bus.dbg_req_ready), 32'(e_dbg));
        chk("mem_en", 32'(bus.mem_en), 32'((e_if || e_dbg) && !bad));
        chk("mem_addr", 32'(bus.mem_addr), (e_if || e_dbg) ? (a / 4) % 1024 : 32'd0);

        has = exp_q.size() > 0;
        r   = '{is_dbg: 1'b0, err: 1'b0, data: 32'd0};
        if (has) r = exp_q.pop_front();
        e_ifv = has && !r.is_dbg && !fl && !rst;
        e_dv  = has && r.is_dbg && !rst;
        chk("if_resp_valid", 32'(bus.if_resp_valid), 32'(e_ifv));
        chk("dbg_resp_valid", 32'(bus.dbg_resp_valid), 32'(e_dv));
        if (e_ifv) begin
            chk("if_resp_data", bus.if_resp_data, r.data);
            chk("if_resp_err", 32'(bus.if_resp_err), 32'(r.err));
        end
        if (e_dv) begin
            chk("dbg_resp_data", bus.dbg_resp_data, r.data);
            chk("dbg_resp_err", 32'(bus.dbg_resp_err), 32'(r.err));
        end

        if (rst) begin
            exp_q.delete();
            last_dbg = 1'b1;
        end else if (e_if || e_dbg) begin
            exp_q.push_back('{is_dbg: e_dbg, err: bad, data: bad ? 32'd0 : a / 4});
            last_dbg = e_dbg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = 32'd0;
        bus.if_flush      = 1'b0;
        bus.dbg_req_valid = 1'b0;
        bus.dbg_req_addr  = 32'd0;
        last_dbg          = 1'b1;
        @(posedge clk);
        #1;

        // Reset with both valid: no grant.
        cycle(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
        cycle(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20);

        // Reset values of the response outputs.
        reset             = 1'b0;
        bus.if_req_valid  = 1'b0;
        bus.dbg_req_valid = 1'b0;
        @(negedge clk);
        chk("rst_if_resp_valid", 32'(bus.if_resp_valid), 32'd0);
        chk("rst_if_resp_data", bus.if_resp_data, 32'd0);
        chk("rst_if_resp_err", 32'(bus.if_resp_err), 32'd0);
        chk("rst_dbg_resp_valid", 32'(bus.dbg_resp_valid), 32'd0);
        chk("rst_dbg_resp_data", bus.dbg_resp_data, 32'd0);
        chk("rst_dbg_resp_err", 32'(bus.dbg_resp_err), 32'd0);
        @(posedge clk);
        #1;

        // First conflict after reset goes to fetch.
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
        idle();

        // Fetch-only stream 0x0, 0x4, 0x8.
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0);
        idle();

        // Both valid for four cycles.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
        idle();

        // Misaligned, then out of range.
        cycle(1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'd0);
        idle();

        // Fetch 0x40, then flush while debug 0x44 (word 17) is valid.
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h48, 1'b1, 1'b1, 32'h44);
        idle();

        // Reset right after accepting fetch 0x8.
        cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 32'h20);
        idle();
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 3) != 0), rand_addr(),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0), rand_addr());
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-read-port instruction block RAM (10-bit word address, 32-bit data, one-cycle registered read) between two requesters: the instruction-fetch stage and a debug/data-side reader that reads the text segment. It accepts at most one request per cycle over valid/ready, drives the BRAM address, and tracks the in-flight owner. One cycle later it routes the BRAM output back to the requester that issued the read. Bad addresses are flagged without corrupting the stream. The block sits between the fetch stage and the instruction BRAM wrapper.

## Interface
- ADDR_W, 10: BRAM word-address width. Byte range is 2^(ADDR_W+2).
- DATA_W, 32: instruction and data width.

- clk  in  1  system clock; all state on posedge
- reset  in  1  synchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  fetch redirect; kills fetch response due this cycle
- if_resp_valid  out  1  fetch response valid; no backpressure
- if_resp_data  out  DATA_W  instruction word
- if_resp_err  out  1  misaligned or out-of-range request
- dbg_req_valid / dbg_req_addr / dbg_req_ready  in/in/out  1/32/1  debug request; same rules as fetch
- dbg_resp_valid / dbg_resp_data / dbg_resp_err  out  1/DATA_W/1  debug response
- mem_en  out  1  BRAM read enable
- mem_addr  out  ADDR_W  BRAM word address = granted addr[ADDR_W+1:2]
- mem_dout  in  DATA_W  BRAM read data, valid the cycle after mem_en

## Operation
- Grant is combinational. At most one of if_req_ready and dbg_req_ready is high per cycle, and ready is high only when the matching valid is high.
- If only one requester is valid, it wins. When both are valid, the winner depends on IMEM_ARB_RR_EN (see Configuration).
- While if_flush is high, fetch is not eligible (if_req_ready=0) and debug may be granted.
- An accepted request loads in-flight register {vld=1, owner, err}.
  - err = (addr[1:0]!=0) or (addr[31:ADDR_W+2]!=0).
  - mem_en = accepted and !err.
  - mem_addr = addr[ADDR_W+1:2] of the winner, or 0 when there is no grant.
- Response cycle: when vld is set, the owner's resp_valid is 1 and resp_data = err ? 0 : mem_dout. The other port's resp_valid is 0.
- Flush: when if_flush is high and the in-flight owner is fetch, if_resp_valid is forced to 0. A debug response in flight is unaffected.
- Requests are pipelined back to back. The in-flight register reloads every cycle (vld = accept), giving one response per cycle.
- Responses have no backpressure. The consumer must take them in the cycle they are presented.
- When neither valid is high, the block does nothing: mem_en=0 and vld clears next cycle.

## Timing
- Request accepted at cycle N; mem_en/mem_addr asserted at N; response valid at N+1. Latency is 1 cycle and throughput is 1 request per cycle.
- Reset values:
  - vld=0, which makes all resp_valid=0.
  - resp_data=0, resp_err=0.
  - rr pointer = "debug last", so fetch has priority first.
- Reset asserted mid-operation: the in-flight response is discarded and nothing is presented at N+1.
- Reset and valid in the same cycle: ready=0, no grant.
- if_flush and a fetch response in the same cycle: the response is dropped. A fetch request in that cycle is not granted.
- An err request occupies its grant slot and returns resp_err=1 with data 0 at N+1. The BRAM is not read.

## Configuration
- IMEM_ARB_RR_EN defined: two-way round robin on simultaneous valids. The pointer updates only on an accepted grant and points away from the last winner.
- IMEM_ARB_RR_EN undefined: fixed priority, fetch always beats debug. No pointer register exists.

## Structure
- Package imem_pkg holds:
  - IMEM_ADDR_W=10 and IMEM_DATA_W=32 defaults.
  - Owner typedef {OWN_IF, OWN_DBG}.
  - Address-check helper constants (alignment mask, range shift).
- One sub-module, imem_rr_pick: 2-way grant picker with last-winner register and the IMEM_ARB_RR_EN switch inside it.

## Test plan
- Fetch-only stream of 0x0, 0x4, 0x8 on consecutive cycles -> if_resp_valid at cycles 1, 2, 3 with BRAM words 0, 1, 2; dbg_resp_valid stays 0.
- Both valid for 4 cycles (fetch 0x10, debug 0x20) with RR_EN -> grants alternate IF, DBG, IF, DBG. Without RR_EN -> 4 IF grants and dbg_req_ready=0 throughout.
- Fetch 0x6 (misaligned) then fetch 0x1000 (out of range, ADDR_W=10) -> two responses with if_resp_err=1, data 0, mem_en=0 both cycles.
- Fetch 0x40 accepted at N, if_flush at N+1 while debug 0x44 is valid -> no fetch response, debug granted at N+1, dbg_resp at N+2 with word 17.
- Reset raised at N+1 after accepting fetch 0x8 at N -> no response at N+1 or N+2. First grant after reset goes to fetch when both are valid.
